deconv_col_feeder: RTL

- Upstream sequencer for the deconvolution column datapath. Buffers one weight channel (NO_COL_KERNEL columns) in a circular buffer and accepts input-feature columns from an upstream stream.
- Drives each input column once, then loops the full weight channel past it column by column, issuing one-cycle load strobes paced by the datapath ready level.
- Repeats for NO_COL_INPUT_FEATURE input columns per channel and NO_CHANNEL channels, then flags completion.

---
 rtl/deconv_col_feeder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/deconv_col_feeder.sv
// Column sequencer for the deconvolution datapath: buffers one weight channel and
// sweeps every buffered weight column past each input column, channel after channel.
module deconv_col_feeder #(
    parameter int BIT_WIDTH            = 8,
    parameter int NO_COL_KERNEL        = 5,
    parameter int NO_COL_INPUT_FEATURE = 8,
    parameter int NO_CHANNEL           = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_start,
    input  logic                                      i_w_valid,
    input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0]        i_w_col,
    output logic                                      o_w_ready,
    input  logic                                      i_ip_valid,
    input  logic [BIT_WIDTH*NO_COL_INPUT_FEATURE-1:0] i_ip_col,
    output logic                                      o_ip_ready,
    input  logic                                      i_dp_ready,
    output logic [BIT_WIDTH*NO_COL_KERNEL-1:0]        o_weight_col,
    output logic [BIT_WIDTH*NO_COL_INPUT_FEATURE-1:0] o_feature_map_col,
    output logic                                      o_enable_loadw,
    output logic                                      o_enable_loadip,
    output logic [2:0]                                o_kernel_column_id,
    output logic [3:0]                                o_input_column_id,
    output logic [3:0]                                o_chnl_id,
    output logic                                      o_chnl_done,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [2:0]                                o_dbg_state
);

    localparam int WW = BIT_WIDTH * NO_COL_KERNEL;
    localparam logic [2:0] LAST_K  = 3'(NO_COL_KERNEL - 1);
    localparam logic [3:0] LAST_IP = 4'(NO_COL_INPUT_FEATURE - 1);
    localparam logic [3:0] LAST_CH = 4'(NO_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_W, S_GET_IP, S_ISSUE_IP, S_ISSUE_W, S_WAIT_LO, S_WAIT_HI, S_CHNL_END
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wbuf [NO_COL_KERNEL];
    logic [2:0]    wr_ptr, rd_ptr, rd_inc;
    logic          k_last, ip_last, ch_last;

    assign rd_inc      = rd_ptr + 3'd1;
    assign k_last      = (rd_ptr == LAST_K);
    assign ip_last     = (o_input_column_id == LAST_IP);
    assign ch_last     = (o_chnl_id == LAST_CH);
    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Upstream handshake: a column transfers on a rising edge where valid and ready are
    // both high; valid while ready is low is ignored, never held or queued.
    // Strobes are combinational on i_dp_ready so one can never appear while it is low.
    always_comb begin
        state_nxt       = state;
        o_w_ready       = 1'b0;
        o_ip_ready      = 1'b0;
        o_enable_loadip = 1'b0;
        o_enable_loadw  = 1'b0;
        o_chnl_done     = 1'b0;
        o_done          = 1'b0;
        case (state)
            S_IDLE: if (i_start) state_nxt = S_FILL_W;
            S_FILL_W: begin
                o_w_ready = 1'b1;
                if (i_w_valid && wr_ptr == LAST_K) state_nxt = S_GET_IP;
            end
            S_GET_IP: begin
                o_ip_ready = 1'b1;
                if (i_ip_valid) state_nxt = S_ISSUE_IP;
            end
            S_ISSUE_IP: if (i_dp_ready) begin
                o_enable_loadip = 1'b1;
                state_nxt       = S_ISSUE_W;
            end
            S_ISSUE_W: if (i_dp_ready) begin
                o_enable_loadw = 1'b1;
                state_nxt      = S_WAIT_LO;
            end
            S_WAIT_LO: if (!i_dp_ready) state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (i_dp_ready) begin
                if (!k_last)       state_nxt = S_ISSUE_W;
                else if (!ip_last) state_nxt = S_GET_IP;
                else               state_nxt = S_CHNL_END;
            end
            S_CHNL_END: begin
                o_chnl_done = 1'b1;
                if (ch_last) begin
                    o_done    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_FILL_W;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // o_weight_col is loaded on entry to ISSUE_W so it already shows wbuf[rd_ptr]
    // during the load strobe cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NO_COL_KERNEL; i++) wbuf[i] <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            o_weight_col       <= '0;
            o_feature_map_col  <= '0;
            o_kernel_column_id <= '0;
            o_input_column_id  <= '0;
            o_chnl_id          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr_ptr            <= '0;
                    rd_ptr            <= '0;
                    o_input_column_id <= '0;
                    o_chnl_id         <= '0;
                end
                S_FILL_W: if (i_w_valid) begin
                    wbuf[wr_ptr] <= i_w_col;
                    if (wr_ptr == LAST_K) begin
                        wr_ptr            <= '0;
                        o_input_column_id <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + 3'd1;
                    end
                end
                S_GET_IP: if (i_ip_valid) o_feature_map_col <= i_ip_col;
                S_ISSUE_IP: if (i_dp_ready) begin
                    rd_ptr       <= '0;
                    o_weight_col <= wbuf[0];
                end
                S_ISSUE_W: if (i_dp_ready) o_kernel_column_id <= rd_ptr;
                S_WAIT_HI: if (i_dp_ready) begin
                    if (!k_last) begin
                        rd_ptr       <= rd_inc;
                        o_weight_col <= wbuf[rd_inc];
                    end else begin
                        rd_ptr <= '0;
                        if (!ip_last) o_input_column_id <= o_input_column_id + 4'd1;
                    end
                end
                S_CHNL_END: begin
                    o_input_column_id <= '0;
                    if (!ch_last) o_chnl_id <= o_chnl_id + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
